// File: rtl/fast_frame_sequencer.sv
// Frame-level controller for the FAST detector: gates a valid/ready pixel source into
// the detector's free-running pixel port and queues flagged keypoints for the descriptor stage.
module fast_frame_sequencer #(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int KP_DEPTH = 16,
    parameter int MAX_KP   = 500
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_frame_req,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_frame_err,
    input  logic        i_pix_valid,
    input  logic [7:0]  i_pix_data,
    output logic        o_pix_ready,
    output logic        o_det_start,
    output logic [7:0]  o_det_pixel,
    input  logic        i_det_flag,
    input  logic [9:0]  i_det_x,
    input  logic [9:0]  i_det_y,
    input  logic [7:0]  i_det_score,
    input  logic        i_det_end,
    output logic        o_kp_valid,
    output logic [27:0] o_kp_data,
    input  logic        i_kp_ready,
    output logic [15:0] o_kp_count,
    output logic [15:0] o_kp_dropped
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int PW   = $clog2(NPIX + 1);
    localparam int AW   = (KP_DEPTH > 1) ? $clog2(KP_DEPTH) : 1;

    localparam logic [PW-1:0] PIX_ONE   = PW'(1);
    localparam logic [PW-1:0] LAST_CNT  = PW'(NPIX - 1);
    localparam logic [AW:0]   DEPTH_OCC = (AW + 1)'(KP_DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   OCC_ONE   = (AW + 1)'(1);
    localparam logic [15:0]   MAX_KP_C  = 16'(MAX_KP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_STREAM,
        S_FLUSH,
        S_ABORT,
        S_DRAIN
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   pix_cnt;
    logic [27:0]     fifo_mem [KP_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     occ;

    logic capture, flush, clear_cnt, load_cnt, inc_cnt;
    logic fifo_full, push, pop, drop;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            pix_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (load_cnt)
                pix_cnt <= PIX_ONE;
            else if (inc_cnt)
                pix_cnt <= pix_cnt + PIX_ONE;
        end
    end

    always_comb begin
        state_nxt    = state;
        o_pix_ready  = 1'b0;
        o_det_start  = 1'b0;
        o_det_pixel  = '0;
        o_frame_done = 1'b0;
        o_frame_err  = 1'b0;
        capture      = 1'b0;
        flush        = 1'b0;
        clear_cnt    = 1'b0;
        load_cnt     = 1'b0;
        inc_cnt      = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_frame_req) begin
                    clear_cnt = 1'b1;
                    state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                o_pix_ready = 1'b1;
                if (i_pix_valid) begin
                    o_det_start = 1'b1;
                    o_det_pixel = i_pix_data;
                    load_cnt    = 1'b1;
                    state_nxt   = S_STREAM;
                end
            end
            S_STREAM: begin
                o_pix_ready = 1'b1;
                capture     = 1'b1;
                if (i_pix_valid) begin
                    o_det_pixel = i_pix_data;
                    inc_cnt     = 1'b1;
                    if (pix_cnt == LAST_CNT)
                        state_nxt = S_FLUSH;
                end else begin
                    // detector cannot stall: an underflow kills the frame and its keypoints
                    flush     = 1'b1;
                    state_nxt = S_ABORT;
                end
            end
            S_FLUSH: begin
                capture = 1'b1;
                if (i_det_end)
                    state_nxt = S_DRAIN;
            end
            S_ABORT: begin
                if (i_det_end) begin
                    o_frame_err = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (occ == '0) begin
                    o_frame_done = 1'b1;
                    state_nxt    = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign o_busy = (state != S_IDLE);

    // full uses registered occupancy, so a same-cycle pop never frees a slot for a push
    assign fifo_full  = (occ == DEPTH_OCC);
    assign push       = capture && i_det_flag && (o_kp_count < MAX_KP_C) && !fifo_full;
    assign drop       = capture && i_det_flag && !push;
    assign o_kp_valid = (occ != '0);
    assign pop        = o_kp_valid && i_kp_ready;
    assign o_kp_data  = fifo_mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {i_det_y, i_det_x, i_det_score};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || clear_cnt) begin
            o_kp_count   <= '0;
            o_kp_dropped <= '0;
        end else begin
            if (push && o_kp_count != '1)
                o_kp_count <= o_kp_count + 16'd1;
            if (drop && o_kp_dropped != '1)
                o_kp_dropped <= o_kp_dropped + 16'd1;
        end
    end

endmodule

// File: tb/tb_fast_frame_sequencer.sv
// Bench for fast_frame_sequencer: directed vector table, hand-written corner frames and
// random frames, all checked every cycle against a queue-based behavioural model.
module tb_fast_frame_sequencer;

    localparam int W  = 16;
    localparam int H  = 12;
    localparam int WH = W * H;
    localparam int D  = 4;
    localparam int MK = 6;

    logic        clk = 1'b0;
    logic        i_rst_n, i_frame_req, i_pix_valid, i_det_flag, i_det_end, i_kp_ready;
    logic [7:0]  i_pix_data, i_det_score;
    logic [9:0]  i_det_x, i_det_y;
    logic        o_busy, o_frame_done, o_frame_err, o_pix_ready, o_det_start, o_kp_valid;
    logic [7:0]  o_det_pixel;
    logic [27:0] o_kp_data;
    logic [15:0] o_kp_count, o_kp_dropped;
    logic        d2_busy, d2_done, d2_err, d2_ready, d2_start, d2_kp_valid;
    logic [7:0]  d2_pixel;
    logic [27:0] d2_kp_data;
    logic [15:0] d2_count, d2_dropped;

    always #5 clk = ~clk;

    fast_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .KP_DEPTH(D), .MAX_KP(MK)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_frame_req(i_frame_req),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_frame_err(o_frame_err),
        .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data), .o_pix_ready(o_pix_ready),
        .o_det_start(o_det_start), .o_det_pixel(o_det_pixel),
        .i_det_flag(i_det_flag), .i_det_x(i_det_x), .i_det_y(i_det_y),
        .i_det_score(i_det_score), .i_det_end(i_det_end),
        .o_kp_valid(o_kp_valid), .o_kp_data(o_kp_data), .i_kp_ready(i_kp_ready),
        .o_kp_count(o_kp_count), .o_kp_dropped(o_kp_dropped)
    );

    fast_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .KP_DEPTH(D), .MAX_KP(2)) dut2 (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_frame_req(i_frame_req),
        .o_busy(d2_busy), .o_frame_done(d2_done), .o_frame_err(d2_err),
        .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data), .o_pix_ready(d2_ready),
        .o_det_start(d2_start), .o_det_pixel(d2_pixel),
        .i_det_flag(i_det_flag), .i_det_x(i_det_x), .i_det_y(i_det_y),
        .i_det_score(i_det_score), .i_det_end(i_det_end),
        .o_kp_valid(d2_kp_valid), .o_kp_data(d2_kp_data), .i_kp_ready(i_kp_ready),
        .o_kp_count(d2_count), .o_kp_dropped(d2_dropped)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // behavioural model: frame phase, accepted-pixel count, keypoint queue, counters
    localparam int P_IDLE = 0, P_ARM = 1, P_STREAM = 2, P_FLUSH = 3, P_ABORT = 4, P_DRAIN = 5;
    int          m_phase = P_IDLE;
    int          m_acc = 0;
    int          m_cnt = 0;
    int          m_drop = 0;
    logic [27:0] m_q[$];
    bit          mon_en = 0;
    bit          e_ready, e_start, e_cap, e_push, e_pop, e_empty;
    logic [7:0]  e_pix;

    int          cyc = 0;
    int          n_start, n_acc, n_done, n_err, n_done2, end_cyc, done_cyc, err_cyc;
    logic [27:0] pop_q[$];
    logic [27:0] pop2_q[$];
    logic [27:0] sent[$];

    always @(negedge clk) begin
        if (mon_en) begin
            e_ready = (m_phase == P_ARM || m_phase == P_STREAM);
            e_start = (m_phase == P_ARM) && i_pix_valid;
            e_pix   = (e_ready && i_pix_valid) ? i_pix_data : 8'h00;
            e_empty = (m_q.size() == 0);
            check("pix_ready", o_pix_ready, e_ready);
            check("det_start", o_det_start, e_start);
            check("det_pixel", o_det_pixel, e_pix);
            check("busy", o_busy, m_phase != P_IDLE);
            check("frame_done", o_frame_done, m_phase == P_DRAIN && e_empty);
            check("frame_err", o_frame_err, m_phase == P_ABORT && i_det_end);
            check("kp_valid", o_kp_valid, !e_empty);
            if (!e_empty) check("kp_data", o_kp_data, m_q[0]);
            check("kp_count", o_kp_count, m_cnt);
            check("kp_dropped", o_kp_dropped, m_drop);
            check("dut2_pix_ready", d2_ready, e_ready);
            check("dut2_det_start", d2_start, e_start);
            check("dut2_det_pixel", d2_pixel, e_pix);
            check("dut2_frame_err", d2_err, m_phase == P_ABORT && i_det_end);

            if (o_det_start) n_start++;
            if (o_pix_ready && i_pix_valid) n_acc++;
            if (o_frame_done) begin n_done++; done_cyc = cyc; end
            if (o_frame_err) begin n_err++; err_cyc = cyc; end
            if (d2_done) n_done2++;
            if (i_det_end) end_cyc = cyc;
            if (o_kp_valid && i_kp_ready) pop_q.push_back(o_kp_data);
            if (d2_kp_valid && i_kp_ready) pop2_q.push_back(d2_kp_data);

            e_pop  = !e_empty && i_kp_ready;
            e_cap  = (m_phase == P_STREAM || m_phase == P_FLUSH);
            e_push = e_cap && i_det_flag && m_cnt < MK && m_q.size() < D;
            if (!i_rst_n) begin
                m_phase = P_IDLE; m_acc = 0; m_cnt = 0; m_drop = 0; m_q.delete();
            end else begin
                if (e_pop) void'(m_q.pop_front());
                if (e_push) begin
                    m_q.push_back({i_det_y, i_det_x, i_det_score});
                    if (m_cnt < 65535) m_cnt++;
                end else if (e_cap && i_det_flag && m_drop < 65535) begin
                    m_drop++;
                end
                case (m_phase)
                    P_IDLE:   if (i_frame_req) begin m_phase = P_ARM; m_cnt = 0; m_drop = 0; end
                    P_ARM:    if (i_pix_valid) begin m_acc = 1; m_phase = P_STREAM; end
                    P_STREAM: if (i_pix_valid) begin
                                  m_acc++;
                                  if (m_acc == WH) m_phase = P_FLUSH;
                              end else begin
                                  m_phase = P_ABORT;
                                  m_q.delete();
                              end
                    P_FLUSH:  if (i_det_end) m_phase = P_DRAIN;
                    P_ABORT:  if (i_det_end) m_phase = P_IDLE;
                    P_DRAIN:  if (e_empty) m_phase = P_IDLE;
                    default:  m_phase = P_IDLE;
                endcase
            end
        end
        cyc++;
    end

    bit flag_map[WH];
    int rdy_map[WH];
    int rdy_mode = 1;

    task automatic clear_stats();
        n_start = 0; n_acc = 0; n_done = 0; n_err = 0; n_done2 = 0;
        end_cyc = -1; done_cyc = -1; err_cyc = -1;
        pop_q.delete(); pop2_q.delete(); sent.delete();
        for (int p = 0; p < WH; p++) begin
            flag_map[p] = 1'b0;
            rdy_map[p]  = 2;
        end
    endtask

    task automatic set_flags(input int n);
        for (int i = 0; i < n; i++) flag_map[20 + 3 * i] = 1'b1;
    endtask

    task automatic drive_ready(input int m);
        if (m == 2)
            i_kp_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode != 0);
        else
            i_kp_ready = (m != 0);
    endtask

    task automatic idle_inputs();
        i_frame_req = 0; i_pix_valid = 0; i_pix_data = '0; i_det_flag = 0;
        i_det_x = '0; i_det_y = '0; i_det_score = '0; i_det_end = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst_n = 0;
        tick();
        tick();
        i_rst_n = 1;
        clear_stats();
    endtask

    task automatic flag_inputs(input bit f);
        i_det_flag = f;
        if (f) begin
            i_det_x = 10'($urandom); i_det_y = 10'($urandom); i_det_score = 8'($urandom);
            sent.push_back({i_det_y, i_det_x, i_det_score});
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (o_busy && k < 400) begin
            drive_ready(2);
            tick();
            k++;
        end
        check("idle_timeout", o_busy, 1'b0);
    endtask

    task automatic frame(input int drop_at, input int end_delay, input int rdy_after, input bit rnd_post);
        i_frame_req = 1; i_pix_valid = 0;
        tick();
        i_frame_req = 0;
        for (int p = 0; p < WH; p++) begin
            drive_ready(rdy_map[p]);
            flag_inputs(flag_map[p]);
            i_pix_data  = 8'($urandom);
            i_pix_valid = (p != drop_at);
            tick();
            if (p == drop_at) break;
        end
        i_pix_valid = 0; i_det_flag = 0;
        for (int d = 0; d <= end_delay; d++) begin
            i_det_end = (d == end_delay);
            drive_ready(2);
            i_det_flag = rnd_post && ($urandom_range(0, 3) == 0);
            if (i_det_flag) begin
                i_det_x = 10'($urandom); i_det_y = 10'($urandom); i_det_score = 8'($urandom);
            end
            tick();
        end
        i_det_end = 0; i_det_flag = 0;
        rdy_mode = rdy_after;
        wait_idle();
    endtask

    typedef struct {
        bit         req, valid, dend;
        logic [7:0] data;
        bit         e_ready, e_start, e_busy, e_err;
        logic [7:0] e_pix;
    } vec_t;

    vec_t vt[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{0, 1, 0, 8'hAA, 0, 0, 0, 0, 8'h00};
        vt[1] = '{1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00};
        vt[2] = '{0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00};
        vt[3] = '{0, 1, 0, 8'h5A, 1, 1, 1, 0, 8'h5A};
        vt[4] = '{0, 1, 0, 8'h33, 1, 0, 1, 0, 8'h33};
        vt[5] = '{1, 1, 0, 8'h77, 1, 0, 1, 0, 8'h77};
        vt[6] = '{0, 0, 0, 8'hFF, 1, 0, 1, 0, 8'h00};
        vt[7] = '{0, 1, 0, 8'h12, 0, 0, 1, 0, 8'h00};
        vt[8] = '{0, 0, 1, 8'h00, 0, 0, 1, 1, 8'h00};
        vt[9] = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00};

        idle_inputs();
        i_kp_ready = 1;
        i_rst_n = 0;
        tick();
        mon_en = 1;
        do_reset();

        // vector table: request, arm, short stream, underflow, abort, return to idle
        for (int i = 0; i < 10; i++) begin
            i_frame_req = vt[i].req; i_pix_valid = vt[i].valid;
            i_pix_data = vt[i].data; i_det_end = vt[i].dend;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), o_pix_ready, vt[i].e_ready);
            check($sformatf("vec%0d_start", i), o_det_start, vt[i].e_start);
            check($sformatf("vec%0d_pixel", i), o_det_pixel, vt[i].e_pix);
            check($sformatf("vec%0d_busy", i), o_busy, vt[i].e_busy);
            check($sformatf("vec%0d_err", i), o_frame_err, vt[i].e_err);
            tick();
        end
        idle_inputs();

        // full frame, three keypoints, downstream always ready
        do_reset();
        set_flags(3);
        rdy_mode = 1;
        frame(-1, 5, 1, 0);
        check("t1_accepted", n_acc, WH);
        check("t1_det_start", n_start, 1);
        check("t1_pops", pop_q.size(), 3);
        if (pop_q.size() == 3)
            for (int i = 0; i < 3; i++) check($sformatf("t1_pop%0d", i), pop_q[i], sent[i]);
        check("t1_done_cnt", n_done, 1);
        check("t1_done_lat", done_cyc, end_cyc + 1);
        check("t1_kp_count", o_kp_count, 3);

        // underflow at pixel 50
        do_reset();
        rdy_mode = 1;
        frame(50, 8, 1, 0);
        check("t2_accepted", n_acc, 50);
        check("t2_err_cnt", n_err, 1);
        check("t2_err_at_end", err_cyc, end_cyc);
        check("t2_done_cnt", n_done, 0);
        check("t2_kp_count", o_kp_count, 0);
        check("t2_kp_valid", o_kp_valid, 0);

        // ten flags against a stalled downstream
        do_reset();
        set_flags(10);
        rdy_mode = 0;
        frame(-1, 4, 1, 0);
        check("t3_kp_count", o_kp_count, 4);
        check("t3_kp_dropped", o_kp_dropped, 6);
        check("t3_pops", pop_q.size(), 4);
        if (pop_q.size() == 4)
            for (int i = 0; i < 4; i++) check($sformatf("t3_pop%0d", i), pop_q[i], sent[i]);
        check("t3_done_cnt", n_done, 1);

        // MAX_KP limit on the second instance
        do_reset();
        set_flags(5);
        rdy_mode = 1;
        frame(-1, 3, 1, 0);
        check("t4_d2_kp_count", d2_count, 2);
        check("t4_d2_kp_dropped", d2_dropped, 3);
        check("t4_d2_pops", pop2_q.size(), 2);
        if (pop2_q.size() == 2)
            for (int i = 0; i < 2; i++) check($sformatf("t4_d2_pop%0d", i), pop2_q[i], sent[i]);
        check("t4_d2_done", n_done2, 1);
        check("t4_d2_busy", d2_busy, 0);
        check("t4_kp_count", o_kp_count, 5);
        check("t4_kp_dropped", o_kp_dropped, 0);

        // flag while full with a simultaneous pop
        do_reset();
        set_flags(5);
        rdy_mode = 0;
        rdy_map[32] = 1;
        frame(-1, 3, 1, 0);
        check("t5_kp_count", o_kp_count, 4);
        check("t5_kp_dropped", o_kp_dropped, 1);
        check("t5_pops", pop_q.size(), 4);
        if (pop_q.size() == 4)
            for (int i = 0; i < 4; i++) check($sformatf("t5_pop%0d", i), pop_q[i], sent[i]);
        check("t5_done_cnt", n_done, 1);

        // reset in the middle of streaming
        do_reset();
        set_flags(1);
        rdy_mode = 0;
        i_frame_req = 1;
        tick();
        i_frame_req = 0;
        for (int p = 0; p < 30; p++) begin
            drive_ready(2);
            flag_inputs(flag_map[p]);
            i_pix_valid = 1; i_pix_data = 8'($urandom);
            tick();
        end
        i_det_flag = 0;
        i_rst_n = 0;
        tick();
        i_rst_n = 1; i_pix_valid = 0;
        check("t6_busy", o_busy, 0);
        check("t6_ready", o_pix_ready, 0);
        check("t6_kp_valid", o_kp_valid, 0);
        check("t6_kp_count", o_kp_count, 0);
        check("t6_det_pixel", o_det_pixel, 0);
        check("t6_det_start", o_det_start, 0);
        tick();
        tick();
        for (int p = 0; p < WH; p++) flag_map[p] = 1'b0;
        rdy_mode = 1;
        frame(-1, 3, 1, 0);
        check("t6_done_cnt", n_done, 1);
        check("t6_err_cnt", n_err, 0);

        // random frames
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int p = 20; p < WH; p++) flag_map[p] = ($urandom_range(0, 7) == 0);
            rdy_mode = 2;
            frame(($urandom_range(0, 1) == 0) ? int'($urandom_range(1, WH - 1)) : -1,
                  int'($urandom_range(0, 15)), 2, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
